// File: rtl/dv_plunger_monitor.sv
// Purpose : filters the packed DV ADC word into per-plunger 4-sample moving
//           averages, debounced RETRACTED/EXTENDED states and sticky faults
//           raised when a plunger does not follow its solenoid command.
// Latency : sample registered at T, sums at T+1, averages + avg_strb at T+2,
//           state/fault at T+3.
// Backpressure: none; frame-strobe driven, every accepted strobe is processed.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   enable              low ignores strb_frame/clear_fault and holds state;
//                       a sample already in the pipeline still completes
//   strb_frame          one-clock frame strobe, captures DVP12_sense
//   DVP12_sense[19:0]   [19:10] plunger 1 counts, [9:0] plunger 2 counts
//   sol_cmd[1:0]        solenoid command per plunger (1 = extend)
//   clear_fault         clears both sticky faults and mismatch counters
//   P1_avg, P2_avg      moving averages (sum of last 4 samples / 4)
//   avg_valid           set once four samples have entered since reset
//   avg_strb            one-clock pulse when new averages are presented
//   plgr_state[1:0]     debounced state per plunger (1 = EXTENDED)
//   plgr_fault[1:0]     sticky command-follow timeout fault per plunger

module dv_plunger_monitor #(
   parameter logic [9:0] THRESH_HI = 10'h200,
   parameter logic [9:0] THRESH_LO = 10'h180,
   parameter logic [2:0] DEBOUNCE  = 3'd2,
   parameter logic [7:0] TIMEOUT   = 8'd6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        strb_frame,
   input  logic [19:0] DVP12_sense,
   input  logic [1:0]  sol_cmd,
   input  logic        clear_fault,
   output logic [9:0]  P1_avg,
   output logic [9:0]  P2_avg,
   output logic        avg_valid,
   output logic        avg_strb,
   output logic [1:0]  plgr_state,
   output logic [1:0]  plgr_fault
);

   typedef enum logic {
      RETRACTED = 1'b0,
      EXTENDED  = 1'b1
   } plgr_st_e;

   logic       cap;
   logic       clr;
   logic       eval_vld;
   logic [9:0] sense_fld [2];
   logic [9:0] avg_all   [2];
   logic [1:0] st_all;
   logic [1:0] flt_all;

   // Pipeline stage flags: v1 = history captured, v2 = sums updated.
   logic       v1_q;
   logic       v2_q;
   logic       strb_q;
   logic       valid_q, valid_d;
   logic [2:0] scnt_q,  scnt_d;

   assign cap = strb_frame & enable;
   assign clr = clear_fault & enable;
   assign sense_fld[0] = DVP12_sense[19:10];
   assign sense_fld[1] = DVP12_sense[9:0];

   // State and fault only move on published averages once the window is full.
   assign eval_vld = strb_q & valid_q;

   always_comb begin
      scnt_d  = scnt_q;
      valid_d = valid_q;
      if (v2_q) begin
         if (scnt_q != 3'd4) begin
            scnt_d = scnt_q + 3'd1;
         end
         // The 4th sample is being published this edge.
         if (scnt_q == 3'd3) begin
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         strb_q  <= 1'b0;
         scnt_q  <= 3'd0;
         valid_q <= 1'b0;
      end else begin
         v1_q    <= cap;
         v2_q    <= v1_q;
         strb_q  <= v2_q;
         scnt_q  <= scnt_d;
         valid_q <= valid_d;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_plgr
      logic [3:0][9:0] hist_q, hist_d;
      logic [9:0]      old_q,  old_d;
      logic [11:0]     sum_q,  sum_d;
      logic [9:0]      avg_q,  avg_d;
      plgr_st_e        st_q,   st_d;
      logic [2:0]      vcnt_q, vcnt_d;
      logic [7:0]      mcnt_q, mcnt_d;
      logic            flt_q,  flt_d;
      logic            vote;
      logic            unused_sum_lsbs;

      // Truncating average drops the two LSBs of the running sum.
      assign unused_sum_lsbs = ^sum_q[1:0];

      // Datapath: history shift, running sum, published average.
      always_comb begin
         hist_d = hist_q;
         old_d  = old_q;
         if (cap) begin
            hist_d = {hist_q[2:0], sense_fld[g]};
            old_d  = hist_q[3];
         end
         sum_d = sum_q;
         // hist_q[0] is still the newest sample here even if another strobe
         // lands this cycle; old_q holds the sample that just fell out.
         if (v1_q) begin
            sum_d = sum_q + {2'b00, hist_q[0]} - {2'b00, old_q};
         end
         avg_d = avg_q;
         if (v2_q) begin
            avg_d = sum_q[11:2];
         end
      end

      // Debounce with hysteresis, then command-follow timeout on the new state.
      always_comb begin
         vote = 1'b0;
         if (st_q == EXTENDED) begin
            vote = (avg_q <= THRESH_LO);
         end else begin
            vote = (avg_q >= THRESH_HI);
         end
         st_d   = st_q;
         vcnt_d = vcnt_q;
         mcnt_d = mcnt_q;
         flt_d  = flt_q;
         if (eval_vld) begin
            if (vote) begin
               if (vcnt_q + 3'd1 == DEBOUNCE) begin
                  st_d   = (st_q == EXTENDED) ? RETRACTED : EXTENDED;
                  vcnt_d = 3'd0;
               end else begin
                  vcnt_d = vcnt_q + 3'd1;
               end
            end else begin
               vcnt_d = 3'd0;
            end
            if (sol_cmd[g] != st_d) begin
               if (mcnt_q < TIMEOUT) begin
                  mcnt_d = mcnt_q + 8'd1;
               end
               if (mcnt_d == TIMEOUT) begin
                  flt_d = 1'b1;
               end
            end else begin
               mcnt_d = 8'd0;
            end
         end
         // Clear beats a fault being set in the same cycle.
         if (clr) begin
            mcnt_d = 8'd0;
            flt_d  = 1'b0;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            hist_q <= '0;
            old_q  <= '0;
            sum_q  <= '0;
            avg_q  <= '0;
            st_q   <= RETRACTED;
            vcnt_q <= '0;
            mcnt_q <= '0;
            flt_q  <= 1'b0;
         end else begin
            hist_q <= hist_d;
            old_q  <= old_d;
            sum_q  <= sum_d;
            avg_q  <= avg_d;
            st_q   <= st_d;
            vcnt_q <= vcnt_d;
            mcnt_q <= mcnt_d;
            flt_q  <= flt_d;
         end
      end

      assign avg_all[g] = avg_q;
      assign st_all[g]  = st_q;
      assign flt_all[g] = flt_q;
   end

   assign P1_avg     = avg_all[0];
   assign P2_avg     = avg_all[1];
   assign avg_valid  = valid_q;
   assign avg_strb   = strb_q;
   assign plgr_state = st_all;
   assign plgr_fault = flt_all;

endmodule
